// File: rtl/shift_unit_seq_if.sv
// Request/response bundle between the control FSM and the sequential shifter.
interface shift_unit_seq_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  data_out;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential one-bit-per-clock shifter/rotator with start/busy/done handshake.
// data_out doubles as the working register and the held result.
module shift_unit_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  shift_unit_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL   = 3'b000,
    OP_SRL   = 3'b001,
    OP_SRA   = 3'b010,
    OP_ROR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_PASS5 = 3'b101,
    OP_PASS6 = 3'b110,
    OP_PASS7 = 3'b111
  } op_t;

  state_t             state;
  op_t                op_r;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  step_d;
  logic               busy_q;
  logic               done_q;

  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // One-bit step of the working register according to the latched op.
  always_comb begin
    step_d = data_q;
    case (op_r)
      OP_SLL:  step_d = {data_q[DATA_W-2:0], 1'b0};
      OP_SRL:  step_d = {1'b0, data_q[DATA_W-1:1]};
      OP_SRA:  step_d = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
      OP_ROR:  step_d = {data_q[0], data_q[DATA_W-1:1]};
      OP_ROL:  step_d = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
      default: step_d = data_q;
    endcase
  end

  // Control FSM; busy/done are registered alongside the state so they
  // always equal the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= OP_SLL;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_q <= bus.data_in;
            op_r   <= op_t'(bus.op);
            cnt    <= bus.shamt;
            busy_q <= 1'b1;
            if (bus.shamt != '0) begin
              state  <= SHIFT;
              done_q <= 1'b0;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= step_d;
          cnt    <= cnt - SHAMT_W'(1);
          if (cnt <= SHAMT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_unit_seq;

  logic clk;
  logic reset_n;
  int   checks;
  int   passed;

  shift_unit_seq_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  shift_unit_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-shift reference built from ordinary shift operators.
  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] d,
                                            input int unsigned n);
    logic [63:0]        dd;
    logic signed [31:0] s;
    logic [31:0]        r;
    dd = {d, d};
    s  = d;
    case (o)
      3'b000:  r = d << n;
      3'b001:  r = d >> n;
      3'b010:  r = s >>> n;
      3'b011:  begin dd = dd >> n; r = dd[31:0]; end
      3'b100:  begin dd = dd << n; r = dd[63:32]; end
      default: r = d;
    endcase
    return r;
  endfunction

  // Issue one operation from IDLE and check the whole handshake cycle by cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] d, input int unsigned n,
                       input logic [31:0] exp, input bit inject);
    logic want_done;
    bus.start   = 1'b1;
    bus.op      = o;
    bus.data_in = d;
    bus.shamt   = 5'(n);
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= n + 1; k++) begin
      bus.start   = inject;
      bus.op      = 3'($urandom);
      bus.data_in = $urandom;
      bus.shamt   = 5'($urandom);
      want_done   = (k == n + 1);
      checks++;
      if (bus.busy !== 1'b1)
        $display("FAIL busy op=%0d n=%0d cycle=%0d got=%b want=1", o, n, k, bus.busy);
      else passed++;
      checks++;
      if (bus.done !== want_done)
        $display("FAIL done op=%0d n=%0d cycle=%0d got=%b want=%b", o, n, k, bus.done, want_done);
      else passed++;
      if (k == n + 1) begin
        checks++;
        if (bus.data_out !== exp)
          $display("FAIL result op=%0d d=%h n=%0d got=%h want=%h", o, d, n, bus.data_out, exp);
        else passed++;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL idle_after op=%0d n=%0d got busy=%b done=%b want 0/0", o, n, bus.busy, bus.done);
    else passed++;
    checks++;
    if (bus.data_out !== exp)
      $display("FAIL hold op=%0d n=%0d got=%h want=%h", o, n, bus.data_out, exp);
    else passed++;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    bus.start   = 1'b1;
    bus.op      = 3'b000;
    bus.data_in = 32'hFFFF_FFFF;
    bus.shamt   = 5'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0)
        $display("FAIL reset cyc=%0d got busy=%b done=%b data=%h want 0/0/0",
                 i, bus.busy, bus.done, bus.data_out);
      else passed++;
    end
    reset_n   = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0)
      $display("FAIL reset_release got busy=%b done=%b data=%h want 0/0/0",
               bus.busy, bus.done, bus.data_out);
    else passed++;
  endtask

  task automatic test_sll;
    do_op(3'b000, 32'h0000_0001, 31, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_sra_srl;
    do_op(3'b010, 32'h8000_00F0, 4, 32'hF800_000F, 1'b0);
    do_op(3'b001, 32'h8000_00F0, 4, 32'h0800_000F, 1'b0);
  endtask

  task automatic test_zero_rotate;
    do_op(3'b011, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0);
    do_op(3'b011, 32'hDEAD_BEEF, 8, 32'hEFDE_ADBE, 1'b0);
    do_op(3'b100, 32'hDEAD_BEEF, 8, 32'hADBE_EFDE, 1'b0);
    do_op(3'b110, 32'h1357_9BDF, 5, 32'h1357_9BDF, 1'b0);
  endtask

  task automatic test_ignored_start;
    do_op(3'b000, 32'h0000_00FF, 8, 32'h0000_FF00, 1'b1);
    do_op(3'b000, 32'h1234_5678, 4, 32'h2345_6780, 1'b0);
  endtask

  task automatic test_reset_mid;
    bus.start   = 1'b1;
    bus.op      = 3'b000;
    bus.data_in = 32'hA5A5_0001;
    bus.shamt   = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0)
        $display("FAIL pre_reset cycle=%0d got busy=%b done=%b want 1/0", k, bus.busy, bus.done);
      else passed++;
      if (k == 5) reset_n = 1'b0;
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0)
      $display("FAIL mid_reset got busy=%b done=%b data=%h want 0/0/0",
               bus.busy, bus.done, bus.data_out);
    else passed++;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL stale_done cycle=%0d got busy=%b done=%b want 0/0", k, bus.busy, bus.done);
      else passed++;
    end
    do_op(3'b000, 32'h0000_0001, 1, 32'h0000_0002, 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] d;
    int unsigned n;
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(7, 0));
      d = $urandom;
      n = $urandom_range(31, 0);
      if (i < 3) n = i;
      do_op(o, d, n, ref_shift(o, d, n), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    passed      = 0;
    reset_n     = 1'b1;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.data_in = '0;
    bus.shamt   = '0;
    test_reset;
    test_sll;
    test_sra_srl;
    test_zero_rotate;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
